// File: rtl/vend_controller.sv
// Vending sequencer: credit, stock, dispense and change handshakes; every input takes effect one cycle later.
// vend_req holds until vend_done and change_valid holds until change_ready. Define VEND_TIMEOUT_EN to refund idle credit.
module vend_controller #(
  parameter int unsigned ITEM0_PRICE    = 3,
  parameter int unsigned ITEM1_PRICE    = 5,
  parameter int unsigned ITEM2_PRICE    = 7,
  parameter int unsigned ITEM3_PRICE    = 10,
  parameter int unsigned MAX_CREDIT     = 99,
  parameter int unsigned STOCK_INIT     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_pulse,
  input  logic [7:0] coin_value,
  input  logic       sel_pulse,
  input  logic [1:0] sel_item,
  input  logic       cancel_pulse,
  input  logic       restock_pulse,
  input  logic       vend_done,
  input  logic       change_ready,
  output logic [7:0] credit,
  output logic       vend_req,
  output logic [1:0] vend_item,
  output logic       change_valid,
  output logic [7:0] change_amount,
  output logic       coin_reject,
  output logic       err_pulse,
  output logic [1:0] err_code,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CREDIT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_SOLD_OUT = 2'b01;
  localparam logic [1:0] ERR_FUNDS    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [7:0] STOCK_FULL = 8'(STOCK_INIT);
  localparam logic [8:0] CREDIT_CAP = 9'(MAX_CREDIT);

  state_t     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic [7:0] stock_q [4];
  logic [7:0] stock_d [4];
  logic [1:0] vend_item_q, vend_item_d;
  logic       coin_reject_q, coin_reject_d;
  logic       err_pulse_q, err_pulse_d;
  logic [1:0] err_code_q, err_code_d;

  logic [7:0] price;
  logic [8:0] coin_sum;
  logic       coin_fits;
  logic       timeout_hit;

  always_comb begin
    price = 8'(ITEM0_PRICE);
    case (sel_item)
      2'd0: price = 8'(ITEM0_PRICE);
      2'd1: price = 8'(ITEM1_PRICE);
      2'd2: price = 8'(ITEM2_PRICE);
      2'd3: price = 8'(ITEM3_PRICE);
      default: price = 8'(ITEM0_PRICE);
    endcase
  end

  // 9-bit sum so an overflowing coin is caught rather than wrapping
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_fits = (coin_sum <= CREDIT_CAP);

`ifdef VEND_TIMEOUT_EN
  logic [15:0] idle_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= 16'd0;
    end else if (state_q != S_CREDIT || coin_pulse || sel_pulse) begin
      idle_cnt_q <= 16'd0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 16'd1;
    end
  end

  assign timeout_hit = (state_q == S_CREDIT) && !coin_pulse && !sel_pulse && !cancel_pulse &&
                       (idle_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  // TIMEOUT_CYCLES has no effect without the timeout build; credit is held indefinitely
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    stock_d       = stock_q;
    vend_item_d   = vend_item_q;
    coin_reject_d = 1'b0;
    err_pulse_d   = 1'b0;
    err_code_d    = ERR_NONE;

    case (state_q)
      S_IDLE: begin
        if (coin_pulse) begin
          if (coin_fits) begin
            credit_d = coin_value;
            state_d  = S_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
        if (restock_pulse) begin
          for (int i = 0; i < 4; i++) stock_d[i] = STOCK_FULL;
        end
      end

      S_CREDIT: begin
        if (cancel_pulse) begin
          coin_reject_d = coin_pulse;
          state_d       = S_CHANGE;
        end else if (sel_pulse) begin
          coin_reject_d = coin_pulse;
          if (stock_q[sel_item] == 8'd0) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_SOLD_OUT;
          end else if (credit_q < price) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_FUNDS;
          end else begin
            credit_d          = credit_q - price;
            stock_d[sel_item] = stock_q[sel_item] - 8'd1;
            vend_item_d       = sel_item;
            state_d           = S_DISPENSE;
          end
        end else if (coin_pulse) begin
          if (coin_fits) begin
            credit_d = coin_sum[7:0];
          end else begin
            coin_reject_d = 1'b1;
          end
        end else if (timeout_hit) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_CHANGE;
        end
      end

      S_DISPENSE: begin
        coin_reject_d = coin_pulse;
        if (vend_done) begin
          state_d = (credit_q != 8'd0) ? S_CHANGE : S_IDLE;
        end
      end

      S_CHANGE: begin
        coin_reject_d = coin_pulse;
        if (change_ready) begin
          credit_d = 8'd0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      credit_q      <= 8'd0;
      vend_item_q   <= 2'd0;
      coin_reject_q <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      for (int i = 0; i < 4; i++) stock_q[i] <= STOCK_FULL;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_item_q   <= vend_item_d;
      coin_reject_q <= coin_reject_d;
      err_pulse_q   <= err_pulse_d;
      err_code_q    <= err_code_d;
      for (int i = 0; i < 4; i++) stock_q[i] <= stock_d[i];
    end
  end

  assign credit        = credit_q;
  assign state         = state_q;
  assign vend_req      = (state_q == S_DISPENSE);
  assign vend_item     = vend_item_q;
  assign change_valid  = (state_q == S_CHANGE);
  assign change_amount = (state_q == S_CHANGE) ? credit_q : 8'd0;
  assign coin_reject   = coin_reject_q;
  assign err_pulse     = err_pulse_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: hand-written vector table, corner sequences, and random traffic against a rule model.
`timescale 1ns/1ps
module tb_vend_controller;

  localparam int TB_TIMEOUT = 20;
  localparam int PRICES [4] = '{3, 5, 7, 10};
  localparam int CAP = 99;
  localparam int STOCK_FULL = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_pulse = 1'b0;
  logic [7:0] coin_value = 8'd0;
  logic       sel_pulse = 1'b0;
  logic [1:0] sel_item = 2'd0;
  logic       cancel_pulse = 1'b0;
  logic       restock_pulse = 1'b0;
  logic       vend_done = 1'b0;
  logic       change_ready = 1'b0;
  logic [7:0] credit;
  logic       vend_req;
  logic [1:0] vend_item;
  logic       change_valid;
  logic [7:0] change_amount;
  logic       coin_reject;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [1:0] state;

  always #5 clk = ~clk;

  vend_controller #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_pulse(coin_pulse), .coin_value(coin_value),
    .sel_pulse(sel_pulse), .sel_item(sel_item),
    .cancel_pulse(cancel_pulse), .restock_pulse(restock_pulse),
    .vend_done(vend_done), .change_ready(change_ready),
    .credit(credit), .vend_req(vend_req), .vend_item(vend_item),
    .change_valid(change_valid), .change_amount(change_amount),
    .coin_reject(coin_reject), .err_pulse(err_pulse), .err_code(err_code),
    .state(state)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: machine phase as the externally visible state number, plain integers elsewhere
  int m_mode, m_credit, m_item, m_idle, m_code;
  int m_stock [4];
  logic m_rej;

  typedef struct {
    logic coin; logic [7:0] cv; logic sel; logic [1:0] si;
    logic cancel; logic restock; logic done; logic ready;
    logic [7:0] e_credit; logic [1:0] e_state; logic e_vreq; logic [1:0] e_vitem;
    logic e_cval; logic [7:0] e_camt; logic e_rej; logic e_err; logic [1:0] e_code;
  } vec_t;

  vec_t tbl [$];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [25:0] act_pack();
    return {credit, state, vend_req, vend_item, change_valid, change_amount,
            coin_reject, err_pulse, err_code};
  endfunction

  function automatic logic [25:0] exp_pack();
    logic [7:0] amt;
    amt = (m_mode == 3) ? m_credit[7:0] : 8'd0;
    return {m_credit[7:0], m_mode[1:0], (m_mode == 2), m_item[1:0], (m_mode == 3), amt,
            m_rej, (m_code != 0), m_code[1:0]};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_credit = 0; m_item = 0; m_idle = 0; m_code = 0; m_rej = 1'b0;
    for (int i = 0; i < 4; i++) m_stock[i] = STOCK_FULL;
  endtask

  task automatic model_step(input logic c, input int cv, input logic s, input int si,
                            input logic can, input logic rs, input logic d, input logic r);
    m_rej = 1'b0;
    m_code = 0;
    if (m_mode == 0) begin
      if (c) begin
        if (cv <= CAP) begin m_credit = cv; m_mode = 1; m_idle = 0; end
        else m_rej = 1'b1;
      end
      if (rs) for (int i = 0; i < 4; i++) m_stock[i] = STOCK_FULL;
    end else if (m_mode == 1) begin
      if (c || s) m_idle = 0;
      if (can) begin
        m_rej = c; m_mode = 3;
      end else if (s) begin
        m_rej = c;
        if (m_stock[si] == 0) m_code = 1;
        else if (m_credit < PRICES[si]) m_code = 2;
        else begin
          m_credit -= PRICES[si]; m_stock[si]--; m_item = si; m_mode = 2;
        end
      end else if (c) begin
        if (m_credit + cv <= CAP) m_credit += cv;
        else m_rej = 1'b1;
      end else begin
`ifdef VEND_TIMEOUT_EN
        m_idle++;
        if (m_idle >= TB_TIMEOUT) begin m_code = 3; m_mode = 3; end
`endif
      end
    end else if (m_mode == 2) begin
      m_rej = c;
      if (d) m_mode = (m_credit > 0) ? 3 : 0;
    end else begin
      m_rej = c;
      if (r) begin m_credit = 0; m_mode = 0; end
    end
  endtask

  task automatic tick(input logic c, input int cv, input logic s, input int si,
                      input logic can, input logic rs, input logic d, input logic r);
    coin_pulse = c; coin_value = cv[7:0]; sel_pulse = s; sel_item = si[1:0];
    cancel_pulse = can; restock_pulse = rs; vend_done = d; change_ready = r;
    @(posedge clk);
    #1;
    model_step(c, cv, s, si, can, rs, d, r);
    coin_pulse = 1'b0; coin_value = 8'd0; sel_pulse = 1'b0; sel_item = 2'd0;
    cancel_pulse = 1'b0; restock_pulse = 1'b0; vend_done = 1'b0; change_ready = 1'b0;
    check_val("model", 32'(act_pack()), 32'(exp_pack()));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic vec_t mk(int c, int cv, int s, int si, int can, int rs, int d, int r,
                              int ec, int es, int evr, int evi, int ecv, int eca, int erj, int eer, int eco);
    vec_t v;
    v.coin = c[0]; v.cv = cv[7:0]; v.sel = s[0]; v.si = si[1:0];
    v.cancel = can[0]; v.restock = rs[0]; v.done = d[0]; v.ready = r[0];
    v.e_credit = ec[7:0]; v.e_state = es[1:0]; v.e_vreq = evr[0]; v.e_vitem = evi[1:0];
    v.e_cval = ecv[0]; v.e_camt = eca[7:0]; v.e_rej = erj[0]; v.e_err = eer[0]; v.e_code = eco[1:0];
    return v;
  endfunction

  initial begin
    //            coin cv sel si can rs dn rdy | credit st vreq vit cval camt rej err code
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0,   5, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0,  10, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 0, 0, 0, 0,   0, 2, 1, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 2, 1, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0,   5, 1, 0, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0,   7, 1, 0, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0,   2, 2, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   2, 3, 0, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   2, 3, 0, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   2, 3, 0, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   2, 3, 0, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0,   2, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,   2, 1, 0, 1, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 1, 0, 0, 0,   2, 3, 0, 1, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 10, 0, 0, 0, 0, 0, 0, 10, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 0, 0, 0,   3, 2, 1, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0,   3, 2, 1, 2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   3, 3, 0, 2, 1, 3, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0,   3, 3, 0, 2, 1, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 2, 0, 0, 0, 0, 0));

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", 32'(act_pack()), 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      vec_t t;
      t = tbl[k];
      tick(t.coin, int'(t.cv), t.sel, int'(t.si), t.cancel, t.restock, t.done, t.ready);
      check_val($sformatf("vec%0d", k), 32'(act_pack()),
                32'({t.e_credit, t.e_state, t.e_vreq, t.e_vitem, t.e_cval, t.e_camt,
                     t.e_rej, t.e_err, t.e_code}));
    end

    // Item 2 has 7 left: sell them all, then it must report sold out
    for (int k = 0; k < 7; k++) begin
      tick(1, 7, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 1, 2, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 1, 0);
    end
    tick(1, 7, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 2, 0, 0, 0, 0);
    check_val("soldout_code", 32'(err_code), 32'd1);
    check_val("soldout_credit", 32'(credit), 32'd7);
    tick(0, 0, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 1, 2, 0, 0, 0, 0);
    check_val("restock_in_credit_ignored", 32'({err_pulse, err_code, state}), 32'({1'b1, 2'd1, 2'd1}));
    tick(0, 0, 0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1, 0, 0);
    tick(1, 7, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 2, 0, 0, 0, 0);
    check_val("restock_idle_sale", 32'({vend_req, vend_item, state}), 32'({1'b1, 2'd2, 2'd2}));
    tick(0, 0, 0, 0, 0, 0, 1, 0);

    // Credit ceiling: 95 + 5 refused, 95 + 4 reaches exactly the cap
    for (int k = 0; k < 9; k++) tick(1, 10, 0, 0, 0, 0, 0, 0);
    tick(1, 5, 0, 0, 0, 0, 0, 0);
    check_val("credit_95", 32'(credit), 32'd95);
    tick(1, 5, 0, 0, 0, 0, 0, 0);
    check_val("ceiling_reject", 32'({coin_reject, credit}), 32'({1'b1, 8'd95}));
    tick(1, 4, 0, 0, 0, 0, 0, 0);
    check_val("ceiling_exact", 32'({coin_reject, credit}), 32'({1'b0, 8'd99}));
    tick(0, 0, 1, 3, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0, 0, 0);
    check_val("dispense_coin_reject", 32'({coin_reject, credit, state}), 32'({1'b1, 8'd89, 2'd2}));
    tick(0, 0, 0, 0, 0, 0, 1, 1);
    check_val("early_ready_change", 32'({change_valid, change_amount}), 32'({1'b1, 8'd89}));
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    check_val("early_ready_done", 32'({change_valid, credit, state}), 32'd0);

    tick(1, 1, 0, 0, 0, 0, 0, 0);
`ifdef VEND_TIMEOUT_EN
    idle(TB_TIMEOUT - 1);
    check_val("timeout_not_yet", 32'({err_pulse, state}), 32'({1'b0, 2'd1}));
    idle(1);
    check_val("timeout_refund", 32'({err_pulse, err_code, state, change_amount}),
              32'({1'b1, 2'd3, 2'd3, 8'd1}));
    idle(1);
    tick(0, 0, 0, 0, 0, 0, 0, 1);
`else
    idle(100);
    check_val("no_timeout_hold", 32'({state, credit}), 32'({2'd1, 8'd1}));
    tick(0, 0, 0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 1);
`endif

    for (int k = 0; k < 4000; k++) begin
      logic c, s, can, rs, d, r;
      int cv;
      c   = ($urandom_range(0, 3) == 0);
      cv  = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 99) : $urandom_range(1, 12);
      s   = ($urandom_range(0, 4) == 0);
      can = ($urandom_range(0, 24) == 0);
      rs  = ($urandom_range(0, 39) == 0);
      d   = ($urandom_range(0, 2) == 0);
      r   = ($urandom_range(0, 2) == 0);
      tick(c, cv, s, $urandom_range(0, 3), can, rs, d, r);
      if (k == 2000) begin
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_reset", 32'(act_pack()), 32'd0);
        #1 rst_n = 1'b1;
        model_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
# vend_controller

Sequencing controller for the vending datapath. Consumes single-cycle coin pulses from the coin front end and accumulates credit. Arbitrates select, cancel and coin events, tracks per-item stock, drives a held dispense handshake to the motor driver, and returns change over a valid/ready handshake. Sits between the coin/button front end and the dispense/change actuators.

## Interface
- `ITEM0_PRICE`, default 3: price of item 0, credit units.
- `ITEM1_PRICE`, default 5: price of item 1.
- `ITEM2_PRICE`, default 7: price of item 2.
- `ITEM3_PRICE`, default 10: price of item 3.
- `MAX_CREDIT`, default 99: credit ceiling, ≤255.
- `STOCK_INIT`, default 8: stock loaded per item at reset/restock, ≤255.
- `TIMEOUT_CYCLES`, default 1000: idle-credit timeout; used only with `VEND_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `coin_pulse` in 1: one-cycle coin-accepted strobe.
- `coin_value` in 8: coin value, valid with `coin_pulse`.
- `sel_pulse` in 1: one-cycle item-select strobe.
- `sel_item` in 2: item index, valid with `sel_pulse`.
- `cancel_pulse` in 1: one-cycle refund request.
- `restock_pulse` in 1: reload all stock to `STOCK_INIT`.
- `vend_done` in 1: dispense actuator finished.
- `change_ready` in 1: change actuator accepts `change_amount`.
- `credit` out 8: current credit.
- `vend_req` out 1: dispense request, held until `vend_done`.
- `vend_item` out 2: item being dispensed.
- `change_valid` out 1: change pending.
- `change_amount` out 8: amount to return.
- `coin_reject` out 1: one-cycle strobe when a coin is not credited; the coin is to be returned.
- `err_pulse` out 1: one-cycle error strobe.
- `err_code` out 2: 01 sold out, 10 insufficient credit, 11 timeout refund; 00 otherwise.
- `state` out 2: 0 IDLE, 1 CREDIT, 2 DISPENSE, 3 CHANGE.

## Operation
- **IDLE** (credit = 0):
  - coin → credit = coin_value → CREDIT.
  - restock → all four stock counters = `STOCK_INIT`.
  - sel/cancel ignored.
- **CREDIT**:
  - Event priority: cancel > sel > coin.
  - cancel → CHANGE.
  - sel, stock[sel_item] = 0 → err 01, remain.
  - sel, credit < price → err 10, remain.
  - Otherwise sel → credit −= price, stock[sel_item] −= 1, latch `vend_item` → DISPENSE.
  - coin → credit += coin_value, unless the 9-bit sum exceeds `MAX_CREDIT`; then `coin_reject` fires and credit is unchanged.
  - A coin arriving in the same cycle as a cancel or sel is not credited: `coin_reject`.
- **DISPENSE**:
  - `vend_req`=1 with `vend_item` stable.
  - On `vend_done`: credit > 0 → CHANGE, else → IDLE.
- **CHANGE**:
  - `change_valid`=1, `change_amount`=credit, both stable.
  - On `change_ready`: credit = 0 → IDLE.
- DISPENSE and CHANGE reject every coin and ignore sel, cancel and restock.
- restock is honoured only in IDLE.
- Price comparison is unsigned 8-bit. Stock never wraps because sel is refused at 0.
- Reset values:
  - state IDLE, credit 0, all stock = `STOCK_INIT`.
  - All strobes, `vend_req`, `change_valid`, `change_amount`, `vend_item` and `err_code` = 0.
- Reset mid-operation aborts any dispense or change. Credit is lost; system-level refund is out of scope.

## Timing
- Every input event is registered. Its effect on `credit`, `state`, strobes and handshake outputs is visible one cycle later.
- `coin_reject`, `err_pulse` and `err_code` are high for exactly one cycle. `err_code` returns to 00 with `err_pulse`.
- `vend_req` rises the cycle after an accepted sel. It falls the cycle after `vend_done` is sampled high.
- `change_valid` rises on CHANGE entry and falls the cycle after `change_valid & change_ready`. Ready may be high early; completion then takes one cycle.
- `vend_done` outside DISPENSE is ignored. `change_ready` outside CHANGE is ignored.

## Configuration
- `VEND_TIMEOUT_EN` defined:
  - A 16-bit inactivity counter runs in CREDIT and clears on any coin or sel event.
  - Reaching `TIMEOUT_CYCLES` → err 11 strobe and transition to CHANGE, refunding the full credit.
- Undefined: the counter is absent; credit is held in CREDIT indefinitely.

## Test plan
- Reset, coins 5+5, sel item 3 (10) → credit 10, `vend_req` with item 3 until `vend_done`, stock[3]=7, IDLE, no change.
- Coins 5+2, sel item 1 (5), `vend_done` → CHANGE with `change_amount`=2. Hold `change_ready` low 3 cycles: outputs stable. Raise it → credit 0, IDLE.
- Coin 2, sel item 0 (3) → err 10, credit stays 2. Then `cancel_pulse` with a simultaneous coin 5 → `coin_reject`, CHANGE with amount 2.
- Sell item 2 eight times, then sel item 2 → err 01. `restock_pulse` in CREDIT ignored. In IDLE, restock → stock 8.
- Credit 95, coin 5 → `coin_reject`, credit 95. Coin in DISPENSE → `coin_reject`, credit unchanged.
- With `VEND_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20: coin 1, idle 20 cycles → err 11, CHANGE amount 1. Without the macro: still CREDIT after 100 cycles.
